// File: rtl/latch_sync_debounce.sv
// ---------------------------------------------------------------------------
// latch_sync_debounce
//   Brings the asynchronous q level of an upstream latch into the clk domain.
//   The level passes through a SYNC_STAGES-deep flop chain. A four-state
//   debounce FSM then accepts a new level only after DEBOUNCE_CYCLES
//   consecutive equal synchronized samples.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-high reset
//   data_in    : asynchronous level from the latch q output
//   enable     : synchronous qualifier; 0 freezes the accepted level and
//                aborts any pending qualification
//   q_stable   : debounced, registered level
//   rise_pulse : one-clk strobe when q_stable goes 0->1
//   fall_pulse : one-clk strobe when q_stable goes 1->0
//   busy       : 1 while a level change is being qualified (CHK states)
//
// There is no handshake. The rise and fall strobes are fire-and-forget
// single-cycle indications. Downstream logic must sample them on the clk
// edge that follows their assertion.
// ---------------------------------------------------------------------------
module latch_sync_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_WIDTH       = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic data_in,
   input  logic enable,
   output logic q_stable,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic busy
);

   typedef enum logic [1:0] {
      S_LOW      = 2'd0,
      S_CHK_HIGH = 2'd1,
      S_HIGH     = 2'd2,
      S_CHK_LOW  = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] DB_CNT  = CNT_WIDTH'(DEBOUNCE_CYCLES);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   q_stable_q, q_stable_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   logic                   s;
   logic [CNT_WIDTH-1:0]   cnt_inc;

   // The synchronizer shifts every cycle, independent of enable.
   assign sync_d  = {sync_q[SYNC_STAGES-2:0], data_in};
   assign s       = sync_q[SYNC_STAGES-1];
   assign cnt_inc = cnt_q + CNT_ONE;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      q_stable_d = q_stable_q;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      if (!enable) begin
         // Abort any pending check. The accepted level stays where it is.
         if (state_q == S_CHK_HIGH) state_d = S_LOW;
         if (state_q == S_CHK_LOW)  state_d = S_HIGH;
         cnt_d = '0;
      end else begin
         case (state_q)
            S_LOW: begin
               if (s) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     state_d    = S_HIGH;
                     q_stable_d = 1'b1;
                     rise_d     = 1'b1;
                     cnt_d      = '0;
                  end else begin
                     state_d = S_CHK_HIGH;
                     cnt_d   = CNT_ONE;
                  end
               end
            end
            S_CHK_HIGH: begin
               // A reversal takes priority even on the completing sample.
               if (!s) begin
                  state_d = S_LOW;
                  cnt_d   = '0;
               end else if (cnt_inc == DB_CNT) begin
                  state_d    = S_HIGH;
                  q_stable_d = 1'b1;
                  rise_d     = 1'b1;
                  cnt_d      = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            S_HIGH: begin
               if (!s) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     state_d    = S_LOW;
                     q_stable_d = 1'b0;
                     fall_d     = 1'b1;
                     cnt_d      = '0;
                  end else begin
                     state_d = S_CHK_LOW;
                     cnt_d   = CNT_ONE;
                  end
               end
            end
            S_CHK_LOW: begin
               if (s) begin
                  state_d = S_HIGH;
                  cnt_d   = '0;
               end else if (cnt_inc == DB_CNT) begin
                  state_d    = S_LOW;
                  q_stable_d = 1'b0;
                  fall_d     = 1'b1;
                  cnt_d      = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               state_d = S_LOW;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q     <= '0;
         state_q    <= S_LOW;
         cnt_q      <= '0;
         q_stable_q <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         q_stable_q <= q_stable_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
      end
   end

   assign q_stable   = q_stable_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign busy       = (state_q == S_CHK_HIGH) || (state_q == S_CHK_LOW);

endmodule

// File: tb/tb_latch_sync_debounce.sv
// ---------------------------------------------------------------------------
// tb_latch_sync_debounce
//   Uses two instances. dut uses the default parameters. dut_b uses
//   SYNC_STAGES=3 and DEBOUNCE_CYCLES=1. The driver pushes the expected
//   strobe events into queues. Each event is encoded as
//   {is_rise, cycle_seen}. Negedge monitors pop an event whenever a strobe
//   is observed and compare it with the popped entry.
// ---------------------------------------------------------------------------
module tb_latch_sync_debounce;

   logic clk = 1'b0;
   logic reset;
   logic data_in, enable;
   logic q_stable, rise_pulse, fall_pulse, busy;
   logic data_in_b;
   logic en_b = 1'b1;
   logic q_stable_b, rise_pulse_b, fall_pulse_b, busy_b;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_b_q[$];

   int   pulses_b = 0;
   int   trans_b  = 0;
   logic q_prev_b = 1'b0;
   logic pat_b [0:11];

   latch_sync_debounce dut (
      .clk(clk), .reset(reset), .data_in(data_in), .enable(enable),
      .q_stable(q_stable), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
      .busy(busy)
   );

   latch_sync_debounce #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut_b (
      .clk(clk), .reset(reset), .data_in(data_in_b), .enable(en_b),
      .q_stable(q_stable_b), .rise_pulse(rise_pulse_b), .fall_pulse(fall_pulse_b),
      .busy(busy_b)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- helpers ----------------
   function automatic logic [31:0] ev(input logic is_rise, input int c);
      return {is_rise, 31'(c)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      logic [31:0] e;
      if (rise_pulse && fall_pulse) begin
         check("dut_both_pulses", 32'(1), 32'(0));
      end else if (rise_pulse || fall_pulse) begin
         if (exp_q.size() == 0) begin
            check("dut_unexpected_pulse", ev(rise_pulse, cyc), 32'(0));
         end else begin
            e = exp_q.pop_front();
            check("dut_pulse_event", ev(rise_pulse, cyc), e);
         end
      end
   end

   always @(negedge clk) begin
      logic [31:0] e;
      if (q_stable_b !== q_prev_b) trans_b++;
      q_prev_b = q_stable_b;
      if (rise_pulse_b && fall_pulse_b) begin
         check("dut_b_both_pulses", 32'(1), 32'(0));
      end else if (rise_pulse_b || fall_pulse_b) begin
         pulses_b++;
         if (exp_b_q.size() == 0) begin
            check("dut_b_unexpected_pulse", ev(rise_pulse_b, cyc), 32'(0));
         end else begin
            e = exp_b_q.pop_front();
            check("dut_b_pulse_event", ev(rise_pulse_b, cyc), e);
         end
      end
   end

   // ---------------- driver ----------------
   initial begin
      logic prev_b;
      reset     = 1'b1;
      data_in   = 1'b1;
      enable    = 1'b1;
      data_in_b = 1'b0;
      pat_b = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

      // 1: reset while data_in is high
      tick(3);
      check("reset_q_stable", 32'(q_stable), 32'(0));
      check("reset_rise", 32'(rise_pulse), 32'(0));
      check("reset_fall", 32'(fall_pulse), 32'(0));
      check("reset_busy", 32'(busy), 32'(0));
      check("reset_q_stable_b", 32'(q_stable_b), 32'(0));
      reset = 1'b0;
      exp_q.push_back(ev(1'b1, cyc + 6));
      tick(10);
      check("rise_q_stable", 32'(q_stable), 32'(1));
      check("rise_busy", 32'(busy), 32'(0));

      // 2: clean fall
      data_in = 1'b0;
      exp_q.push_back(ev(1'b0, cyc + 6));
      tick(10);
      check("fall_q_stable", 32'(q_stable), 32'(0));

      // 3: two-cycle glitch is rejected
      data_in = 1'b1;
      tick(2);
      data_in = 1'b0;
      tick(1);
      check("glitch_busy_a", 32'(busy), 32'(1));
      tick(1);
      check("glitch_busy_b", 32'(busy), 32'(1));
      check("glitch_q_stable", 32'(q_stable), 32'(0));
      tick(1);
      check("glitch_busy_end", 32'(busy), 32'(0));
      tick(6);

      // 4: enable dropped at cnt=3, then qualification restarts
      data_in = 1'b1;
      tick(5);
      check("en_busy_cnt3", 32'(busy), 32'(1));
      enable = 1'b0;
      tick(1);
      check("en_off_busy", 32'(busy), 32'(0));
      check("en_off_q_stable", 32'(q_stable), 32'(0));
      tick(2);
      enable = 1'b1;
      exp_q.push_back(ev(1'b1, cyc + 4));
      tick(3);
      check("en_restart_busy", 32'(busy), 32'(1));
      tick(5);
      check("en_rise_q_stable", 32'(q_stable), 32'(1));

      // 5: reset during S_CHK_LOW
      data_in = 1'b0;
      tick(4);
      check("rst_mid_busy", 32'(busy), 32'(1));
      reset = 1'b1;
      #1;
      check("rst_mid_q_stable", 32'(q_stable), 32'(0));
      check("rst_mid_busy_clr", 32'(busy), 32'(0));
      tick(3);
      reset = 1'b0;
      tick(10);
      check("rst_mid_after_q", 32'(q_stable), 32'(0));

      // 6: SYNC_STAGES=3, DEBOUNCE_CYCLES=1; every change passes 4 edges later
      prev_b = 1'b0;
      for (int i = 0; i < 12; i++) begin
         data_in_b = pat_b[i];
         if (pat_b[i] != prev_b) exp_b_q.push_back(ev(pat_b[i], cyc + 4));
         prev_b = pat_b[i];
         tick(1);
      end
      tick(8);
      check("b_final_q_stable", 32'(q_stable_b), 32'(0));
      check("b_pulse_count", 32'(pulses_b), 32'(6));
      check("b_pulses_vs_transitions", 32'(pulses_b), 32'(trans_b));

      // no expected events left unobserved
      check("dut_queue_empty", 32'(exp_q.size()), 32'(0));
      check("dut_b_queue_empty", 32'(exp_b_q.size()), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
